// File: rtl/seq_trig_pkg.sv
// Shared types and constants for the sequence-trigger monitor.
package seq_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  localparam logic [127:0] PAYLOAD_INIT_DEF = {64{2'b10}};

endpackage

// File: rtl/seq_trig_payload.sv
// Activity register: rotates right by one bit on every enabled cycle to give a
// fixed, repeatable switching signature while the trigger is active.
module seq_trig_payload
  import seq_trig_pkg::*;
#(
  parameter int                   PAYLOAD_W    = 128,
  parameter logic [PAYLOAD_W-1:0] PAYLOAD_INIT = PAYLOAD_W'(PAYLOAD_INIT_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [PAYLOAD_W-1:0] payload
);

  // Shift form keeps the rotate legal for every width, including 1.
  function automatic logic [PAYLOAD_W-1:0] ror1(input logic [PAYLOAD_W-1:0] v);
    return (v >> 1) | (v << (PAYLOAD_W - 1));
  endfunction

  // stage p0: payload register
  always_ff @(posedge clk) begin
    if (rst) begin
      payload <= PAYLOAD_INIT;
    end else if (en) begin
      payload <= ror1(payload);
    end
  end

endmodule

// File: rtl/seq_trigger_monitor.sv
// Ordered sequence detector with sticky trigger and rotating activity payload.
// Optional MATCH-state watchdog enabled by defining SEQ_TRIG_TIMEOUT_EN.
module seq_trigger_monitor
  import seq_trig_pkg::*;
#(
  parameter int                   DATA_W       = 128,
  parameter int                   DEPTH        = 4,
  parameter int                   STRICT       = 0,
  parameter int                   PAYLOAD_W    = 128,
  parameter logic [PAYLOAD_W-1:0] PAYLOAD_INIT = PAYLOAD_W'(PAYLOAD_INIT_DEF),
  parameter int                   TIMEOUT_CYC  = 1024,
  localparam int                  IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int                  STG_W        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [DATA_W-1:0]    cfg_pattern,
  output logic [STG_W-1:0]     stage,
  output logic                 trig,
  output logic [PAYLOAD_W-1:0] payload
);

  if (DEPTH < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $fatal(1, "seq_trigger_monitor: DEPTH and TIMEOUT_CYC must be >= 1");
  end

  state_t            state;
  logic [DATA_W-1:0] pat [DEPTH];
  logic [DATA_W-1:0] cur_pat;
  logic              hit;
  logic              miss;
  logic              first_hit;
  logic              last;

  // Slot writes beyond DEPTH-1 match no loop index and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pat[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cfg_we && cfg_idx == IDX_W'(i)) pat[i] <= cfg_pattern;
      end
    end
  end

  // Pattern select by loop avoids an index wider than the table.
  always_comb begin
    cur_pat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage == STG_W'(i)) cur_pat = pat[i];
    end
  end

  assign hit       = in_valid && (state != ST_FIRED) && (in_data == cur_pat);
  assign miss      = in_valid && !hit;
  assign first_hit = (in_data == pat[0]);
  assign last      = (stage == STG_W'(DEPTH - 1));

`ifdef SEQ_TRIG_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog;
`endif

  // stage p0: sequence FSM, stage counter, sticky trigger
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      stage <= '0;
      trig  <= 1'b0;
`ifdef SEQ_TRIG_TIMEOUT_EN
      wdog  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            stage <= STG_W'(1);
`ifdef SEQ_TRIG_TIMEOUT_EN
            wdog  <= '0;
`endif
            if (DEPTH == 1) begin
              state <= ST_FIRED;
              trig  <= 1'b1;
            end else begin
              state <= ST_MATCH;
            end
          end
        end
        ST_MATCH: begin
          if (hit) begin
            stage <= stage + STG_W'(1);
`ifdef SEQ_TRIG_TIMEOUT_EN
            wdog  <= '0;
`endif
            if (last) begin
              state <= ST_FIRED;
              trig  <= 1'b1;
            end
          end else if (miss && STRICT != 0) begin
            // A mismatching word may itself be the start of a fresh sequence.
            if (first_hit) begin
              stage <= STG_W'(1);
`ifdef SEQ_TRIG_TIMEOUT_EN
              wdog  <= '0;
`endif
            end else begin
              stage <= '0;
              state <= ST_IDLE;
            end
          end else begin
`ifdef SEQ_TRIG_TIMEOUT_EN
            if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
              stage <= '0;
              state <= ST_IDLE;
            end else begin
              wdog <= wdog + WD_W'(1);
            end
`endif
          end
        end
        ST_FIRED: begin
          state <= ST_FIRED;
        end
        default: begin
          state <= ST_IDLE;
          stage <= '0;
        end
      endcase
    end
  end

  // stage p1: activity register follows the registered trigger
  seq_trig_payload #(
    .PAYLOAD_W    (PAYLOAD_W),
    .PAYLOAD_INIT (PAYLOAD_INIT)
  ) u_payload (
    .clk     (clk),
    .rst     (rst),
    .en      (trig),
    .payload (payload)
  );

endmodule

// File: tb/tb_seq_trigger_monitor.sv
// Directed scoreboard bench for seq_trigger_monitor: sticky (dut0), strict (dut1)
// and DEPTH=3 (dut2) instances share one stimulus stream.
module tb_seq_trigger_monitor;

  localparam logic [127:0] P0   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2   = 128'h0;
  localparam logic [127:0] P3   = 128'h1;
  localparam logic [127:0] PX   = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
  localparam logic [127:0] PN   = 128'hcafef00d_00000000_00000000_00000077;
  localparam logic [127:0] INIT = {64{2'b10}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_idx = '0;
  logic [127:0] cfg_pattern = '0;

  logic [2:0]   st0, st1;
  logic [1:0]   st2;
  logic         tr0, tr1, tr2;
  logic [127:0] pl0, pl1, pl2;

  always #5 clk = ~clk;

  seq_trigger_monitor #(.DEPTH(4), .STRICT(0), .TIMEOUT_CYC(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
    .stage(st0), .trig(tr0), .payload(pl0));

  seq_trigger_monitor #(.DEPTH(4), .STRICT(1), .TIMEOUT_CYC(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
    .stage(st1), .trig(tr1), .payload(pl1));

  seq_trigger_monitor #(.DEPTH(3), .STRICT(0), .TIMEOUT_CYC(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
    .stage(st2), .trig(tr2), .payload(pl2));

  typedef struct {
    string        tag;
    logic [2:0]   s0;
    logic         t0;
    logic [127:0] p0;
    logic [2:0]   s1;
    logic         t1;
    logic [127:0] p1;
    bit           c2;
    logic [1:0]   s2;
    logic         t2;
    logic [127:0] p2;
  } exp_t;

  exp_t sbq[$];
  logic [127:0] mp0 = INIT, mp1 = INIT, mp2 = INIT;
  logic         mt0 = 1'b0, mt1 = 1'b0, mt2 = 1'b0;
  int errors = 0;
  int checks = 0;

  function automatic logic [127:0] ror1(input logic [127:0] v);
    return {v[0], v[127:1]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Push the expected post-edge outputs, clock once, then pop and compare.
  task automatic stp(input string tag, input int s0, input int t0, input int s1, input int t1,
                     input int s2 = -1, input int t2 = 0);
    exp_t e;
    e.tag = tag;
    e.s0 = 3'(s0); e.t0 = 1'(t0); e.p0 = rst ? INIT : (mt0 ? ror1(mp0) : mp0);
    e.s1 = 3'(s1); e.t1 = 1'(t1); e.p1 = rst ? INIT : (mt1 ? ror1(mp1) : mp1);
    e.c2 = (s2 >= 0);
    e.s2 = 2'(s2); e.t2 = 1'(t2); e.p2 = rst ? INIT : (mt2 ? ror1(mp2) : mp2);
    mp0 = e.p0; mt0 = e.t0; mp1 = e.p1; mt1 = e.t1; mp2 = e.p2; mt2 = e.t2;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".stage0"}, 128'(st0), 128'(e.s0));
    chk({e.tag, ".trig0"}, 128'(tr0), 128'(e.t0));
    chk({e.tag, ".payload0"}, pl0, e.p0);
    chk({e.tag, ".stage1"}, 128'(st1), 128'(e.s1));
    chk({e.tag, ".trig1"}, 128'(tr1), 128'(e.t1));
    chk({e.tag, ".payload1"}, pl1, e.p1);
    if (e.c2) begin
      chk({e.tag, ".stage2"}, 128'(st2), 128'(e.s2));
      chk({e.tag, ".trig2"}, 128'(tr2), 128'(e.t2));
      chk({e.tag, ".payload2"}, pl2, e.p2);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic vw(input logic [127:0] d, input string tag, input int s0, input int t0,
                    input int s1, input int t1, input int s2 = -1, input int t2 = 0);
    in_valid = 1'b1;
    in_data = d;
    stp(tag, s0, t0, s1, t1, s2, t2);
  endtask

  task automatic reset_load(input string tag, input bit c2);
    rst = 1'b1;
    stp({tag, "_rst"}, 0, 0, 0, 0, c2 ? 0 : -1, 0);
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1;
      cfg_idx = 2'(i);
      cfg_pattern = (i == 0) ? P0 : (i == 1) ? P1 : (i == 2) ? P2 : P3;
      stp($sformatf("%s_load%0d", tag, i), 0, 0, 0, 0, c2 ? 0 : -1, 0);
    end
  endtask

  initial begin
    // Full sequence with gaps, then rotation while fired.
    reset_load("a", 1'b0);
    vw(P0, "a_w0", 1, 0, 1, 0);
    in_data = P1;
    stp("a_novalid", 1, 0, 1, 0);
    vw(P1, "a_w1", 2, 0, 2, 0);
    stp("a_gap1", 2, 0, 2, 0);
    vw(P2, "a_w2", 3, 0, 3, 0);
    stp("a_gap2", 3, 0, 3, 0);
    vw(P3, "a_w3", 4, 1, 4, 1);
    vw(PX, "a_fired_miss", 4, 1, 4, 1);
    chk("a_payload_5555", pl0, {64{2'b01}});
    stp("a_rot2", 4, 1, 4, 1);
    chk("a_payload_aaaa", pl0, {64{2'b10}});

    // Reset while fired; unrelated word between stages 2 and 3.
    reset_load("b", 1'b0);
    vw(P0, "b_w0", 1, 0, 1, 0);
    vw(P1, "b_w1", 2, 0, 2, 0);
    vw(PX, "b_unrel", 2, 0, 0, 0);
    vw(P2, "b_w2", 3, 0, 0, 0);
    vw(P3, "b_w3", 4, 1, 0, 0);
    stp("b_hold", 4, 1, 0, 0);

    // Strict replay of pat[0] restarts at stage 1.
    reset_load("c", 1'b0);
    vw(P0, "c_w0", 1, 0, 1, 0);
    vw(P1, "c_w1", 2, 0, 2, 0);
    vw(P0, "c_replay", 2, 0, 1, 0);

    // Out-of-order words and a non-valid matching word.
    reset_load("o", 1'b0);
    vw(P0, "o_w0", 1, 0, 1, 0);
    vw(P2, "o_w2", 1, 0, 0, 0);
    vw(P3, "o_w3", 1, 0, 0, 0);
    in_data = P1;
    stp("o_novalid", 1, 0, 0, 0);

    // Same-cycle write and hit on slot 1: old value matches, new value rules later.
    reset_load("d", 1'b0);
    vw(P0, "d_w0", 1, 0, 1, 0);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_pattern = PN;
    vw(P1, "d_cfg_hit", 2, 0, 2, 0);
    vw(P0, "d_restart", 2, 0, 1, 0);
    vw(P1, "d_old_dead", 2, 0, 0, 0);
    vw(P0, "d_restart2", 2, 0, 1, 0);
    vw(PN, "d_new", 2, 0, 2, 0);
    vw(P2, "d_w2", 3, 0, 3, 0);
    vw(P3, "d_w3", 4, 1, 4, 1);

    // DEPTH=3 instance ignores the slot-3 write and fires after three words.
    reset_load("e", 1'b1);
    vw(P0, "e_w0", 1, 0, 1, 0, 1, 0);
    vw(P1, "e_w1", 2, 0, 2, 0, 2, 0);
    vw(P2, "e_w2", 3, 0, 3, 0, 3, 1);
    vw(P3, "e_w3", 4, 1, 4, 1, 3, 1);
    stp("e_rot", 4, 1, 4, 1, 3, 1);

`ifdef SEQ_TRIG_TIMEOUT_EN
    reset_load("f", 1'b0);
    vw(P0, "f_w0", 1, 0, 1, 0);
    vw(P1, "f_w1", 2, 0, 2, 0);
    for (int i = 1; i <= 7; i++) stp($sformatf("f_idle%0d", i), 2, 0, 2, 0);
    stp("f_timeout", 0, 0, 0, 0);
    vw(P0, "f_w0b", 1, 0, 1, 0);
    vw(P1, "f_w1b", 2, 0, 2, 0);
    for (int i = 1; i <= 7; i++) stp($sformatf("f_idleb%0d", i), 2, 0, 2, 0);
    vw(P2, "f_hit_on_8th", 3, 0, 3, 0);
    for (int i = 1; i <= 7; i++) stp($sformatf("f_idlec%0d", i), 3, 0, 3, 0);
    stp("f_timeout2", 0, 0, 0, 0);
`else
    reset_load("f", 1'b0);
    vw(P0, "f_w0", 1, 0, 1, 0);
    vw(P1, "f_w1", 2, 0, 2, 0);
    for (int i = 1; i <= 20; i++) stp($sformatf("f_notimeout%0d", i), 2, 0, 2, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
